pipe_ctrl: RTL

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 119 +++++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: prioritises exception, memory wait, multi-cycle EX and
// load-use stalls, and issues a single-cycle flush with PC redirect on exceptions.
module pipe_ctrl #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_id_stallreq,
  input  logic              i_ex_mc_start,
  input  logic [CNT_W-1:0]  i_ex_mc_len,
  input  logic              i_mem_req,
  input  logic              i_mem_ack,
  input  logic              i_exc_valid,
  input  logic [ADDR_W-1:0] i_exc_handler_pc,
  output logic [5:0]        o_stall,
  output logic              o_flush,
  output logic [ADDR_W-1:0] o_new_pc,
  output logic              o_mc_busy
);

  localparam logic [5:0] StallNone = 6'b000000;
  localparam logic [5:0] StallId   = 6'b000111;
  localparam logic [5:0] StallEx   = 6'b001111;
  localparam logic [5:0] StallMem  = 6'b011111;

  typedef enum logic [1:0] {StRun, StMc, StMemw, StFlush} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mc_go;
  logic              lower;
  logic [5:0]        stall;
  logic              flush;
  logic [ADDR_W-1:0] new_pc;
  logic              mc_busy;

  // A zero-length multi-cycle request carries no work and is dropped.
  assign mc_go = i_ex_mc_start && (i_ex_mc_len != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StRun;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = StallNone;
    flush   = 1'b0;
    new_pc  = '0;
    mc_busy = 1'b0;
    lower   = 1'b0;

    if (i_exc_valid) begin
      flush   = 1'b1;
      new_pc  = i_exc_handler_pc;
      state_d = StFlush;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StFlush: state_d = StRun;
        StRun: begin
          if (i_mem_req && !i_mem_ack) begin
            stall   = StallMem;
            state_d = StMemw;
          end else begin
            lower = 1'b1;
          end
        end
        StMemw: begin
          if (!i_mem_ack) begin
            stall = StallMem;
          end else begin
            // Ack cycle behaves like RUN with the memory source retired.
            state_d = StRun;
            lower   = 1'b1;
          end
        end
        StMc: begin
          mc_busy = 1'b1;
          if (i_mem_req && !i_mem_ack) begin
            stall = StallMem;
          end else begin
            stall = StallEx;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = StRun;
          end
        end
        default: state_d = StRun;
      endcase

      if (lower) begin
        if (mc_go) begin
          stall   = StallEx;
          mc_busy = 1'b1;
          cnt_d   = i_ex_mc_len - CNT_W'(1);
          state_d = (i_ex_mc_len > CNT_W'(1)) ? StMc : StRun;
        end else if (i_id_stallreq) begin
          stall = StallId;
        end
      end
    end
  end

  // Outputs are forced quiet for as long as reset is held, independent of the clock.
  always_comb begin
    o_stall   = rst ? StallNone : stall;
    o_flush   = rst ? 1'b0 : flush;
    o_new_pc  = rst ? '0 : new_pc;
    o_mc_busy = rst ? 1'b0 : mc_busy;
  end

endmodule
